// File: rtl/deal_arb_pkg.sv
// Shared types for the deal arbiter: FSM encoding, requester IDs, field widths.
package deal_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DELIVER = 3'd3,
        ST_EMPTY   = 3'd4
    } state_t;

    localparam int PLAYER = 0;
    localparam int DEALER = 1;
    localparam int RANK_W = 4;
    localparam int SUIT_W = 2;
    localparam int CNT_W  = 6;
    localparam int STAT_W = 4;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; remembers the last granted requester (resets to dealer).
import deal_arb_pkg::*;

module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       update,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       last
);

    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = (last == 1'(DEALER)) ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= 1'(DEALER);
        else if (clr)
            last <= 1'(DEALER);
        else if (update && (|req))
            last <= grant[DEALER];
    end

endmodule

// File: rtl/deal_arbiter.sv
// Arbitrates player/dealer card requests onto one card deck with a fixed fetch latency.
// Optional per-requester ack counters are enabled by defining DEAL_ARBITER_STATS_EN.
// Handshake: a requester holds its req level until its one-cycle ack; dropping req
// after the grant lets the fetch finish but the card is discarded with no ack.
import deal_arb_pkg::*;

module deal_arbiter #(
    parameter int NUM_CARDS = 52,
    parameter int DECK_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              new_round,
    input  logic              player_req,
    input  logic              dealer_req,
    output logic              player_ack,
    output logic              dealer_ack,
    output logic [RANK_W-1:0] card_num,
    output logic [SUIT_W-1:0] card_suit,
    output logic              deck_pip,
    input  logic [RANK_W-1:0] deck_number,
    input  logic [SUIT_W-1:0] deck_suits,
    input  logic              deck_empty,
    output logic              busy,
    output logic              exhausted,
    output logic [CNT_W-1:0]  dealt_cnt,
    output state_t            dbg_state
`ifdef DEAL_ARBITER_STATS_EN
    ,
    output logic [STAT_W-1:0] player_cnt,
    output logic [STAT_W-1:0] dealer_cnt
`endif
);

    localparam logic [1:0]       LAT_M1 = 2'(DECK_LAT - 1);
    localparam logic [CNT_W-1:0] LAST_CARD = CNT_W'(NUM_CARDS);

    state_t     state;
    logic [1:0] wait_cnt;
    logic       winner;
    logic [1:0] grant;
    logic       last_grant;
    logic       win_req;

    assign dbg_state = state;
    assign win_req   = winner ? dealer_req : player_req;

    rr_arb2 u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (new_round),
        .update (state == ST_IDLE && !new_round),
        .req    ({dealer_req, player_req}),
        .grant  (grant),
        .last   (last_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wait_cnt   <= 2'd0;
            winner     <= 1'b0;
            player_ack <= 1'b0;
            dealer_ack <= 1'b0;
            card_num   <= '0;
            card_suit  <= '0;
            deck_pip   <= 1'b0;
            busy       <= 1'b0;
            exhausted  <= 1'b0;
            dealt_cnt  <= '0;
`ifdef DEAL_ARBITER_STATS_EN
            player_cnt <= '0;
            dealer_cnt <= '0;
`endif
        end else if (new_round) begin
            // Abort any fetch in flight; the captured card is kept on the outputs.
            state      <= ST_IDLE;
            wait_cnt   <= 2'd0;
            player_ack <= 1'b0;
            dealer_ack <= 1'b0;
            deck_pip   <= 1'b0;
            busy       <= 1'b0;
            exhausted  <= 1'b0;
            dealt_cnt  <= '0;
`ifdef DEAL_ARBITER_STATS_EN
            player_cnt <= '0;
            dealer_cnt <= '0;
`endif
        end else begin
            player_ack <= 1'b0;
            dealer_ack <= 1'b0;
            deck_pip   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (player_req || dealer_req) begin
                        winner   <= grant[DEALER];
                        state    <= ST_ISSUE;
                        deck_pip <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= 2'd0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == LAT_M1) begin
                        if (deck_empty) begin
                            state     <= ST_EMPTY;
                            exhausted <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            state     <= ST_DELIVER;
                            dealt_cnt <= dealt_cnt + 1'b1;
                            if (win_req) begin
                                card_num   <= deck_number;
                                card_suit  <= deck_suits;
                                player_ack <= !winner;
                                dealer_ack <= winner;
`ifdef DEAL_ARBITER_STATS_EN
                                if (winner) dealer_cnt <= sat_inc(dealer_cnt);
                                else        player_cnt <= sat_inc(player_cnt);
`endif
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                ST_DELIVER: begin
                    busy <= 1'b0;
                    if (dealt_cnt == LAST_CARD) begin
                        state     <= ST_EMPTY;
                        exhausted <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_EMPTY: state <= ST_EMPTY;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_deal_arbiter.sv
// Directed bench for deal_arbiter (DECK_LAT=1); stats checks run when DEAL_ARBITER_STATS_EN is defined.
import deal_arb_pkg::*;

module tb_deal_arbiter;

`ifdef DEAL_ARBITER_STATS_EN
    localparam int NC = 32;
`else
    localparam int NC = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        new_round = 1'b0;
    logic        player_req = 1'b0;
    logic        dealer_req = 1'b0;
    logic        player_ack, dealer_ack;
    logic [3:0]  card_num;
    logic [1:0]  card_suit;
    logic        deck_pip;
    logic [3:0]  deck_number = 4'd0;
    logic [1:0]  deck_suits = 2'd0;
    logic        deck_empty = 1'b0;
    logic        busy, exhausted;
    logic [5:0]  dealt_cnt;
    state_t      dbg_state;
`ifdef DEAL_ARBITER_STATS_EN
    logic [3:0]  player_cnt, dealer_cnt;
`endif

    int checks = 0;
    int errors = 0;

    deal_arbiter #(.NUM_CARDS(NC), .DECK_LAT(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .new_round   (new_round),
        .player_req  (player_req),
        .dealer_req  (dealer_req),
        .player_ack  (player_ack),
        .dealer_ack  (dealer_ack),
        .card_num    (card_num),
        .card_suit   (card_suit),
        .deck_pip    (deck_pip),
        .deck_number (deck_number),
        .deck_suits  (deck_suits),
        .deck_empty  (deck_empty),
        .busy        (busy),
        .exhausted   (exhausted),
        .dealt_cnt   (dealt_cnt),
        .dbg_state   (dbg_state)
`ifdef DEAL_ARBITER_STATS_EN
        ,
        .player_cnt  (player_cnt),
        .dealer_cnt  (dealer_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_new_round();
        new_round = 1'b1;
        tick();
        new_round = 1'b0;
    endtask

    // Single-requester deal with a bounded wait for the ack.
    task automatic deal(input bit dealer, input logic [3:0] num, input logic [1:0] suit);
        bit got;
        got = 1'b0;
        deck_number = num;
        deck_suits  = suit;
        if (dealer) dealer_req = 1'b1; else player_req = 1'b1;
        for (int t = 0; t < 10 && !got; t++) begin
            tick();
            got = dealer ? dealer_ack : player_ack;
        end
        chk("deal_ack", 32'(got), 32'd1);
        player_req = 1'b0;
        dealer_req = 1'b0;
        tick();
    endtask

    initial begin
        bit got;
        // Reset values
        tick(); tick();
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rst_outs", {player_ack, dealer_ack, deck_pip, busy, exhausted, card_num, card_suit, dealt_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();

        // First deal: pip one cycle after request, ack two cycles later
        deck_number = 4'd7;
        deck_suits  = 2'd2;
        player_req  = 1'b1;
        tick();
        chk("first_pip", 32'(deck_pip), 32'd1);
        chk("first_busy", 32'(busy), 32'd1);
        tick();
        chk("first_pip_one_cycle", 32'(deck_pip), 32'd0);
        chk("first_no_early_ack", 32'(player_ack), 32'd0);
        tick();
        chk("first_ack", {player_ack, dealer_ack}, 32'b10);
        chk("first_card", {card_num, card_suit}, {4'd7, 2'd2});
        chk("first_dealt", 32'(dealt_cnt), 32'd1);
        player_req = 1'b0;
        tick();
        chk("first_ack_pulse", 32'(player_ack), 32'd0);
        chk("first_idle", {29'd0, busy, 2'd0} | 32'(dbg_state), 32'(ST_IDLE));

        pulse_new_round();
        chk("nr_dealt", 32'(dealt_cnt), 32'd0);

        // Both held: alternate player/dealer until the deck is exhausted
        player_req = 1'b1;
        dealer_req = 1'b1;
        for (int i = 0; i < NC; i++) begin
            deck_number = 4'(1 + (i % 13));
            deck_suits  = 2'(i);
            got = 1'b0;
            for (int t = 0; t < 10 && !got; t++) begin
                tick();
                got = player_ack | dealer_ack;
            end
            chk("rr_got_ack", 32'(got), 32'd1);
            chk("rr_order", {player_ack, dealer_ack}, (i % 2 == 0) ? 32'b10 : 32'b01);
            chk("rr_card", {card_num, card_suit}, {4'(1 + (i % 13)), 2'(i)});
        end
        tick();
        chk("exh_flag", 32'(exhausted), 32'd1);
        chk("exh_state", 32'(dbg_state), 32'(ST_EMPTY));
        chk("exh_dealt", 32'(dealt_cnt), 32'(NC));
        for (int t = 0; t < 6; t++) begin
            tick();
            chk("exh_quiet", {deck_pip, player_ack, dealer_ack}, 32'd0);
        end
        player_req = 1'b0;
        dealer_req = 1'b0;
`ifdef DEAL_ARBITER_STATS_EN
        chk("stat_p_sat", 32'(player_cnt), 32'd15);
        chk("stat_d_sat", 32'(dealer_cnt), 32'd15);
`endif
        pulse_new_round();
        chk("nr_exh_clear", {exhausted, dealt_cnt}, 32'd0);
`ifdef DEAL_ARBITER_STATS_EN
        chk("stat_clear", {player_cnt, dealer_cnt}, 32'd0);
        deal(1'b0, 4'd1, 2'd0);
        deal(1'b1, 4'd2, 2'd1);
        deal(1'b0, 4'd3, 2'd2);
        deal(1'b1, 4'd4, 2'd3);
        deal(1'b0, 4'd5, 2'd0);
        chk("stat_p3", 32'(player_cnt), 32'd3);
        chk("stat_d2", 32'(dealer_cnt), 32'd2);
        pulse_new_round();
`endif

        // Deck reports empty at capture
        deck_empty = 1'b1;
        player_req = 1'b1;
        tick();
        tick();
        chk("empty_no_early_ack", 32'(player_ack), 32'd0);
        tick();
        chk("empty_no_ack", {player_ack, dealer_ack}, 32'd0);
        chk("empty_exh", 32'(exhausted), 32'd1);
        chk("empty_dealt", 32'(dealt_cnt), 32'd0);
        chk("empty_state", 32'(dbg_state), 32'(ST_EMPTY));
        player_req = 1'b0;
        deck_empty = 1'b0;
        pulse_new_round();
        chk("empty_nr", {exhausted, dealt_cnt}, 32'd0);

        // new_round during WAIT aborts; pending dealer request is served afterwards
        deck_number = 4'd9;
        deck_suits  = 2'd1;
        player_req  = 1'b1;
        dealer_req  = 1'b1;
        tick();
        chk("abort_pip", 32'(deck_pip), 32'd1);
        tick();
        chk("abort_in_wait", 32'(dbg_state), 32'(ST_WAIT));
        new_round  = 1'b1;
        player_req = 1'b0;
        tick();
        new_round = 1'b0;
        chk("abort_no_ack", {player_ack, dealer_ack}, 32'd0);
        chk("abort_idle", 32'(dbg_state), 32'(ST_IDLE));
        chk("abort_busy", 32'(busy), 32'd0);
        tick();
        tick();
        tick();
        chk("abort_dealer_ack", {player_ack, dealer_ack}, 32'b01);
        chk("abort_card", {card_num, card_suit}, {4'd9, 2'd1});
        chk("abort_dealt", 32'(dealt_cnt), 32'd1);
        dealer_req = 1'b0;
        tick();

        // Request withdrawn after grant: card discarded, count still advances
        deck_number = 4'd3;
        deck_suits  = 2'd0;
        player_req  = 1'b1;
        tick();
        player_req = 1'b0;
        tick();
        tick();
        chk("disc_no_ack", {player_ack, dealer_ack}, 32'd0);
        chk("disc_dealt", 32'(dealt_cnt), 32'd2);
        chk("disc_card_held", {card_num, card_suit}, {4'd9, 2'd1});
        tick();

        // Reset in the middle of a fetch
        player_req = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {busy, deck_pip, dealt_cnt, card_num, card_suit}, 32'd0);
        chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        player_req = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("mid_rst_no_ack", {player_ack, dealer_ack, deck_pip}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
